noc_ni_bridge: RTL and testbench

Network-interface endpoint at the processing-element side of a NoC router port. The TX path frames PE write requests into header + payload AXI-stream messages and drives them into a router ingress. The RX path accepts messages from a router egress, checks the destination and framing, strips the header and hands the payload to the PE. Drop and error statistics are kept in saturating counters.

---
 rtl/noc_pkg.sv | 32 +++
 rtl/noc_ni_rx_deframer.sv | 106 ++++++++++
 rtl/noc_ni_bridge.sv | 102 ++++++++++
 tb/tb_noc_ni_bridge.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: header layout, field widths and the framer/deframer state encodings.
// Every stream here uses one handshake rule: a beat moves when valid && ready at a rising clk edge, and a source holds valid and data until that happens.
package noc_pkg;
    localparam int NODE_ID_W = 4;
    localparam int LEN_W     = 8;
    localparam int HDR_W     = 16;

    typedef logic [NODE_ID_W-1:0] node_id_t;
    typedef logic [LEN_W-1:0]     len_t;

    // Occupies flit bits [15:0]; dest is the most significant field.
    typedef struct packed {
        node_id_t dest;
        node_id_t src;
        len_t     len;
    } noc_hdr_t;

    typedef enum logic [1:0] {T_IDLE, T_HDR, T_PAY} tx_state_t;
    typedef enum logic [1:0] {R_HDR, R_PAY, R_DROP} rx_state_t;

    function automatic logic [HDR_W-1:0] pack_hdr(node_id_t dest, node_id_t src, len_t len);
        noc_hdr_t h;
        h.dest = dest;
        h.src  = src;
        h.len  = len;
        return h;
    endfunction

    function automatic noc_hdr_t unpack_hdr(logic [HDR_W-1:0] flit);
        return noc_hdr_t'(flit);
    endfunction
endpackage

// File: rtl/noc_ni_rx_deframer.sv
// RX side of the network interface: checks header dest and framing, strips the header,
// forwards the payload to the PE and keeps the saturating drop/error counters.
module noc_ni_rx_deframer
    import noc_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int NODE_ID = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_tvalid,
    output logic              rx_tready,
    input  logic [DATA_W-1:0] rx_tdata,
    input  logic              rx_tlast,
    output logic              pe_rx_valid,
    input  logic              pe_rx_ready,
    output logic [DATA_W-1:0] pe_rx_data,
    output logic [3:0]        pe_rx_src,
    output logic              pe_rx_last,
    output logic [15:0]       drop_cnt,
    output logic [15:0]       err_cnt,
    output rx_state_t         state_dbg
);
    rx_state_t state, state_nxt;
    node_id_t  src_q;
    len_t      len_q, beat_cnt;
    noc_hdr_t  hdr;
    logic      drop_evt, err_evt, hdr_take, beat_inc;

    assign state_dbg = state;

    always_comb begin
        state_nxt   = state;
        rx_tready   = 1'b0;
        pe_rx_valid = 1'b0;
        pe_rx_data  = '0;
        pe_rx_src   = '0;
        pe_rx_last  = 1'b0;
        drop_evt    = 1'b0;
        err_evt     = 1'b0;
        hdr_take    = 1'b0;
        beat_inc    = 1'b0;
        hdr         = unpack_hdr(rx_tdata[HDR_W-1:0]);
        case (state)
            R_HDR: begin
                rx_tready = 1'b1;
                if (rx_tvalid) begin
                    // A header that is also the last flit carries no payload at all.
                    if (rx_tlast) begin
                        err_evt = 1'b1;
                    end else if (hdr.dest != node_id_t'(NODE_ID)) begin
                        drop_evt  = 1'b1;
                        state_nxt = R_DROP;
                    end else begin
                        hdr_take  = 1'b1;
                        state_nxt = R_PAY;
                    end
                end
            end
            R_PAY: begin
                pe_rx_valid = rx_tvalid;
                rx_tready   = pe_rx_ready;
                pe_rx_data  = rx_tdata;
                pe_rx_src   = src_q;
                pe_rx_last  = (beat_cnt == len_q);
                if (rx_tvalid && pe_rx_ready) begin
                    beat_inc = 1'b1;
                    if (rx_tlast) begin
                        err_evt   = !pe_rx_last;
                        state_nxt = R_HDR;
                    end else if (pe_rx_last) begin
                        err_evt   = 1'b1;
                        state_nxt = R_DROP;
                    end
                end
            end
            R_DROP: begin
                rx_tready = 1'b1;
                if (rx_tvalid && rx_tlast) state_nxt = R_HDR;
            end
            default: state_nxt = R_HDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= R_HDR;
            src_q    <= '0;
            len_q    <= '0;
            beat_cnt <= '0;
            drop_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (hdr_take) begin
                src_q    <= hdr.src;
                len_q    <= hdr.len;
                beat_cnt <= '0;
            end else if (beat_inc) begin
                beat_cnt <= beat_cnt + 8'd1;
            end
            if (drop_evt && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            if (err_evt && err_cnt != 16'hFFFF)   err_cnt  <= err_cnt + 16'd1;
        end
    end
endmodule

// File: rtl/noc_ni_bridge.sv
// PE-side NoC network interface: TX framer (header + payload pass-through into router ingress)
// and the RX deframer instance for router egress.
module noc_ni_bridge
    import noc_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int NODE_ID = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pe_tx_valid,
    output logic              pe_tx_ready,
    input  logic [3:0]        pe_tx_dest,
    input  logic [7:0]        pe_tx_len,
    input  logic [DATA_W-1:0] pe_tx_data,
    output logic              tx_tvalid,
    input  logic              tx_tready,
    output logic [DATA_W-1:0] tx_tdata,
    output logic              tx_tlast,
    input  logic              rx_tvalid,
    output logic              rx_tready,
    input  logic [DATA_W-1:0] rx_tdata,
    input  logic              rx_tlast,
    output logic              pe_rx_valid,
    input  logic              pe_rx_ready,
    output logic [DATA_W-1:0] pe_rx_data,
    output logic [3:0]        pe_rx_src,
    output logic              pe_rx_last,
    output logic [15:0]       drop_cnt,
    output logic [15:0]       err_cnt,
    output tx_state_t         tx_state_dbg,
    output rx_state_t         rx_state_dbg
);
    tx_state_t tx_state, tx_state_nxt;
    node_id_t  dest_q;
    len_t      len_q, beat_cnt;

    assign tx_state_dbg = tx_state;

    always_comb begin
        tx_state_nxt = tx_state;
        pe_tx_ready  = 1'b0;
        tx_tvalid    = 1'b0;
        tx_tdata     = '0;
        tx_tlast     = 1'b0;
        case (tx_state)
            T_IDLE: if (pe_tx_valid) tx_state_nxt = T_HDR;
            T_HDR: begin
                // Built only from registered fields, so the header is stable while stalled.
                tx_tvalid = 1'b1;
                tx_tdata  = DATA_W'(pack_hdr(dest_q, node_id_t'(NODE_ID), len_q));
                if (tx_tready) tx_state_nxt = T_PAY;
            end
            T_PAY: begin
                tx_tvalid   = pe_tx_valid;
                pe_tx_ready = tx_tready;
                tx_tdata    = pe_tx_data;
                tx_tlast    = (beat_cnt == len_q);
                if (pe_tx_valid && tx_tready && tx_tlast) tx_state_nxt = T_IDLE;
            end
            default: tx_state_nxt = T_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state <= T_IDLE;
            dest_q   <= '0;
            len_q    <= '0;
            beat_cnt <= '0;
        end else begin
            tx_state <= tx_state_nxt;
            if (tx_state == T_IDLE && pe_tx_valid) begin
                dest_q   <= pe_tx_dest;
                len_q    <= pe_tx_len;
                beat_cnt <= '0;
            end else if (tx_state == T_PAY && pe_tx_valid && tx_tready) begin
                beat_cnt <= beat_cnt + 8'd1;
            end
        end
    end

    noc_ni_rx_deframer #(
        .DATA_W (DATA_W),
        .NODE_ID(NODE_ID)
    ) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_tvalid  (rx_tvalid),
        .rx_tready  (rx_tready),
        .rx_tdata   (rx_tdata),
        .rx_tlast   (rx_tlast),
        .pe_rx_valid(pe_rx_valid),
        .pe_rx_ready(pe_rx_ready),
        .pe_rx_data (pe_rx_data),
        .pe_rx_src  (pe_rx_src),
        .pe_rx_last (pe_rx_last),
        .drop_cnt   (drop_cnt),
        .err_cnt    (err_cnt),
        .state_dbg  (rx_state_dbg)
    );
endmodule

// File: tb/tb_noc_ni_bridge.sv
// Scoreboard bench for noc_ni_bridge: drivers push expected flits/words from a message-level
// model, independent negedge monitors pop and compare on every handshake.
module tb_noc_ni_bridge;
    import noc_pkg::*;

    localparam int W = 32;
    localparam logic [3:0] NID = 4'd1;

    logic          clk, rst_n;
    logic          pe_tx_valid, pe_tx_ready;
    logic [3:0]    pe_tx_dest;
    logic [7:0]    pe_tx_len;
    logic [W-1:0]  pe_tx_data;
    logic          tx_tvalid, tx_tready, tx_tlast;
    logic [W-1:0]  tx_tdata;
    logic          rx_tvalid, rx_tready, rx_tlast;
    logic [W-1:0]  rx_tdata;
    logic          pe_rx_valid, pe_rx_ready, pe_rx_last;
    logic [W-1:0]  pe_rx_data;
    logic [3:0]    pe_rx_src;
    logic [15:0]   drop_cnt, err_cnt;
    tx_state_t     tx_state_dbg;
    rx_state_t     rx_state_dbg;

    int checks = 0;
    int errors = 0;
    logic [W:0]   tx_exp_q[$];   // {tlast, data}
    logic [W+4:0] rx_exp_q[$];   // {last, src, data}
    int exp_drop = 0;
    int exp_err  = 0;
    int tx_mode  = 0;            // 0: always ready, 1: toggle, 2: random
    int rx_mode  = 0;            // 0: always ready, else random
    logic         tx_stall_prev;
    logic [W:0]   tx_prev_flit;

    noc_ni_bridge #(.DATA_W(W), .NODE_ID(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .pe_tx_valid(pe_tx_valid), .pe_tx_ready(pe_tx_ready), .pe_tx_dest(pe_tx_dest),
        .pe_tx_len(pe_tx_len), .pe_tx_data(pe_tx_data),
        .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .tx_tdata(tx_tdata), .tx_tlast(tx_tlast),
        .rx_tvalid(rx_tvalid), .rx_tready(rx_tready), .rx_tdata(rx_tdata), .rx_tlast(rx_tlast),
        .pe_rx_valid(pe_rx_valid), .pe_rx_ready(pe_rx_ready), .pe_rx_data(pe_rx_data),
        .pe_rx_src(pe_rx_src), .pe_rx_last(pe_rx_last),
        .drop_cnt(drop_cnt), .err_cnt(err_cnt),
        .tx_state_dbg(tx_state_dbg), .rx_state_dbg(rx_state_dbg)
    );

    // Clock / reset / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Sink-side ready generators
    initial begin
        tx_tready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (tx_mode)
                0:       tx_tready = 1'b1;
                1:       tx_tready = ~tx_tready;
                default: tx_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        pe_rx_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            pe_rx_ready = (rx_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    // Monitors
    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_stall_prev) begin
                check("tx_hold_valid", 64'(tx_tvalid), 64'd1);
                check("tx_hold_flit", 64'({tx_tlast, tx_tdata}), 64'(tx_prev_flit));
            end
            if (tx_state_dbg == T_PAY) check("tx_ready_mirror", 64'(pe_tx_ready), 64'(tx_tready));
            if (tx_tvalid && tx_exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL tx_unexpected actual=%0h expected=none", tx_tdata);
            end else if (tx_tvalid && tx_tready) begin
                check("tx_flit", 64'({tx_tlast, tx_tdata}), 64'(tx_exp_q.pop_front()));
            end
            tx_stall_prev <= tx_tvalid && !tx_tready;
            tx_prev_flit  <= {tx_tlast, tx_tdata};
        end else begin
            tx_stall_prev <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (pe_rx_valid && rx_exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rx_unexpected actual=%0h expected=none", pe_rx_data);
            end else if (pe_rx_valid && pe_rx_ready) begin
                check("rx_word", 64'({pe_rx_last, pe_rx_src, pe_rx_data}), 64'(rx_exp_q.pop_front()));
            end
        end
    end

    // Driver tasks
    task automatic tx_accept();
        int n = 0;
        @(negedge clk);
        while (!pe_tx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!pe_tx_ready) begin
            checks++; errors++;
            $display("FAIL tx_accept_timeout actual=0 expected=1");
        end
        @(posedge clk); #1;
    endtask

    task automatic send_tx(input logic [3:0] dest, input logic [7:0] len, input bit chk_lat);
        logic [W-1:0] w;
        tx_exp_q.push_back({1'b0, 16'h0000, dest, NID, len});
        @(posedge clk); #1;
        pe_tx_valid = 1'b1;
        pe_tx_dest  = dest;
        pe_tx_len   = len;
        pe_tx_data  = $urandom;
        if (chk_lat) begin
            @(negedge clk);
            check("tx_idle_no_valid", 64'(tx_tvalid), 64'd0);
            @(negedge clk);
            check("tx_hdr_latency", 64'(tx_tvalid), 64'd1);
            @(posedge clk); #1;
        end
        for (int i = 0; i <= int'(len); i++) begin
            w = $urandom;
            tx_exp_q.push_back({(i == int'(len)), w});
            pe_tx_data = w;
            tx_accept();
        end
        pe_tx_valid = 1'b0;
    endtask

    task automatic send_rx_flit(input logic [W-1:0] data, input logic last);
        int n = 0;
        rx_tvalid = 1'b1;
        rx_tdata  = data;
        rx_tlast  = last;
        @(negedge clk);
        while (!rx_tready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!rx_tready) begin
            checks++; errors++;
            $display("FAIL rx_accept_timeout actual=0 expected=1");
        end
        @(posedge clk); #1;
    endtask

    // Message-level model: p payload flits follow the header, tlast on the final flit.
    task automatic send_rx_msg(input logic [3:0] dest, input logic [3:0] src, input logic [7:0] len,
                               input int p, input logic [15:0] upper);
        logic [W-1:0] words[$];
        for (int i = 0; i < p; i++) words.push_back($urandom);
        if (p == 0) exp_err++;
        else if (dest != NID) exp_drop++;
        else begin
            for (int i = 0; i < p && i <= int'(len); i++)
                rx_exp_q.push_back({(i == int'(len)), src, words[i]});
            if (p != int'(len) + 1) exp_err++;
        end
        @(posedge clk); #1;
        send_rx_flit({upper, dest, src, len}, (p == 0));
        for (int i = 0; i < p; i++) send_rx_flit(words[i], (i == p - 1));
        rx_tvalid = 1'b0;
        rx_tlast  = 1'b0;
    endtask

    task automatic drain_and_check(input string tag);
        int n = 0;
        while ((tx_exp_q.size() != 0 || rx_exp_q.size() != 0) && n < 1000) begin
            @(posedge clk);
            n++;
        end
        check({tag, "_tx_pending"}, 64'(tx_exp_q.size()), 64'd0);
        check({tag, "_rx_pending"}, 64'(rx_exp_q.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_drop_cnt"}, 64'(drop_cnt), 64'(exp_drop));
        check({tag, "_err_cnt"}, 64'(err_cnt), 64'(exp_err));
    endtask

    // Main sequence
    initial begin
        logic [W-1:0] y;
        logic [3:0]   d;
        logic [7:0]   l;
        int           p;
        rst_n = 1'b0;
        pe_tx_valid = 1'b0; pe_tx_dest = '0; pe_tx_len = '0; pe_tx_data = '0;
        rx_tvalid = 1'b0; rx_tdata = '0; rx_tlast = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_tvalid", 64'(tx_tvalid), 64'd0);
        check("rst_pe_tx_ready", 64'(pe_tx_ready), 64'd0);
        check("rst_tx_tdata", 64'(tx_tdata), 64'd0);
        check("rst_rx_tready", 64'(rx_tready), 64'd1);
        check("rst_pe_rx_valid", 64'(pe_rx_valid), 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        check("rst_err_cnt", 64'(err_cnt), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Basic TX, then TX under toggling backpressure
        send_tx(4'd3, 8'd2, 1'b1);
        tx_mode = 1;
        send_tx(4'd3, 8'd2, 1'b0);
        send_tx(NID, 8'd0, 1'b0);

        // Good RX, misaddressed RX, early tlast, missing tlast
        rx_mode = 1;
        send_rx_msg(NID, 4'd5, 8'd2, 3, 16'h0000);
        drain_and_check("rx_good");
        send_rx_msg(4'd7, 4'd2, 8'd3, 4, 16'h0000);
        send_rx_msg(NID, 4'd6, 8'd1, 2, 16'h0000);
        drain_and_check("rx_drop");
        send_rx_msg(NID, 4'd2, 8'd3, 2, 16'h0000);
        drain_and_check("rx_early_tlast");
        send_rx_msg(NID, 4'd2, 8'd1, 3, 16'h0000);
        send_rx_msg(NID, 4'd3, 8'd0, 0, 16'h0000);
        drain_and_check("rx_missing_tlast");

        // Reset while TX and RX are both mid-payload
        tx_mode = 0;
        rx_mode = 0;
        @(posedge clk); #1;
        pe_tx_valid = 1'b1; pe_tx_dest = 4'd2; pe_tx_len = 8'd3; pe_tx_data = $urandom;
        tx_exp_q.push_back({1'b0, 16'h0000, 4'd2, NID, 8'd3});
        rx_tvalid = 1'b1; rx_tlast = 1'b0; rx_tdata = {16'h0000, NID, 4'd4, 8'd3};
        @(posedge clk); #1;
        y = $urandom;
        rx_tdata = y;
        rx_exp_q.push_back({1'b0, 4'd4, y});
        @(posedge clk); #1;
        rst_n = 1'b0; pe_tx_valid = 1'b0; rx_tvalid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_drop = 0;
        exp_err  = 0;
        @(negedge clk);
        check("mid_rst_tx_tvalid", 64'(tx_tvalid), 64'd0);
        check("mid_rst_pe_rx_valid", 64'(pe_rx_valid), 64'd0);
        check("mid_rst_rx_tready", 64'(rx_tready), 64'd1);
        check("mid_rst_drop_cnt", 64'(drop_cnt), 64'd0);
        check("mid_rst_err_cnt", 64'(err_cnt), 64'd0);
        send_tx(4'd5, 8'd1, 1'b0);
        send_rx_msg(NID, 4'd6, 8'd1, 2, 16'h0000);
        drain_and_check("post_rst");

        // Randomized traffic on both directions concurrently
        tx_mode = 2;
        rx_mode = 1;
        fork
            begin
                for (int k = 0; k < 20; k++) send_tx(4'($urandom_range(0, 15)), 8'($urandom_range(0, 6)), 1'b0);
                send_tx(4'd9, 8'd255, 1'b0);
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    d = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(2, 15)) : NID;
                    l = 8'($urandom_range(0, 4));
                    case ($urandom_range(0, 7))
                        0:       p = 0;
                        1:       p = (l > 0) ? int'(l) : 1;
                        2:       p = int'(l) + 1 + $urandom_range(1, 2);
                        default: p = int'(l) + 1;
                    endcase
                    send_rx_msg(d, 4'($urandom_range(0, 15)), l, p, 16'($urandom));
                end
            end
        join
        drain_and_check("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
